// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with round-robin tie-break, busy back-pressure and WAIT timeout.
// Define ARB_STATS_EN to build the 64-bit busy-cycle and transfer counters.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we0,
   input  logic              we1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_busy,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [63:0]       stat_busy_cycles,
   output logic [63:0]       stat_xfers
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q,  last_d;
   logic [1:0]          gnt_q,   gnt_d;
   logic [1:0]          done_q,  done_d;
   logic                err_q,   err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q,    we_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic                sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_d   = '0;
      done_d  = '0;
      err_d   = 1'b0;
      rdata_d = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      // On a tie the requester that did not complete last wins.
      sel     = (req[0] & req[1]) ? ~last_q : req[1];

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = ISSUE;
               owner_d     = sel;
               gnt_d[sel]  = 1'b1;
               addr_d      = sel ? addr1  : addr0;
               wdata_d     = sel ? wdata1 : wdata0;
               we_d        = sel ? we1    : we0;
               cnt_d       = '0;
            end
         end
         ISSUE: begin
            if (!mem_busy) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d         = IDLE;
               done_d[owner_q] = 1'b1;
               rdata_d         = we_q ? '0 : mem_rdata;
               last_d          = owner_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d         = IDLE;
               done_d[owner_q] = 1'b1;
               err_d           = 1'b1;
               last_d          = owner_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == ISSUE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;

`ifdef ARB_STATS_EN
   logic [63:0] busy_cnt_q, xfer_cnt_q;

   // Transfers are counted on the edge that launches the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt_q <= '0;
         xfer_cnt_q <= '0;
      end else begin
         if (state_q == ISSUE && mem_busy) busy_cnt_q <= busy_cnt_q + 64'd1;
         if (|done_d)                      xfer_cnt_q <= xfer_cnt_q + 64'd1;
      end
   end

   assign stat_busy_cycles = busy_cnt_q;
   assign stat_xfers       = xfer_cnt_q;
`else
   assign stat_busy_cycles = '0;
   assign stat_xfers       = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT_CYCLES, 64, maximum WAIT cycles before error completion (range 2..1024).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  2  per-requester request (bit0 = core, bit1 = external master); held high until gnt.
REQ-005 addr0/addr1  in  ADDR_W each  request address.
REQ-006 wdata0/wdata1  in  DATA_W each  write data.
REQ-007 we0/we1  in  1 each  1 = write, 0 = read.
REQ-008 gnt  out  2  one-cycle pulse; request fields captured.
REQ-009 done  out  2  one-cycle completion pulse to owner.
REQ-010 err  out  1  valid with done; 1 = timeout completion.
REQ-011 rdata  out  DATA_W  read data; valid with done.
REQ-012 mem_req  out  1  memory-side request valid.
REQ-013 mem_addr/mem_wdata/mem_we  out  ADDR_W/DATA_W/1  latched request fields.
REQ-014 mem_busy  in  1  memory back-pressure; request not accepted while high.
REQ-015 mem_rvalid  in  1  completion strobe for reads and writes.
REQ-016 mem_rdata  in  DATA_W  read data, valid with mem_rvalid.
REQ-017 stat_busy_cycles, stat_xfers  out  64 each  performance counters (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE: on an edge with any req bit high -> ISSUE; winner's fields latched into mem_addr/mem_wdata/mem_we; owner register set.
REQ-020 Arbitration: single requester wins; both high -> requester not equal to last_grant wins (round-robin).
REQ-021 gnt[owner] SHALL be high exactly during the first ISSUE cycle (registered, 1-cycle latency from req).
REQ-022 mem_req SHALL be high in every ISSUE cycle and low in IDLE and WAIT.
REQ-023 Handshake: accepted at an edge with mem_req=1 and mem_busy=0 -> WAIT; mem_busy=1 holds ISSUE with stable fields, indefinitely.
REQ-024 mem_rvalid SHALL be sampled only in WAIT; ignored in IDLE and ISSUE.
REQ-025 WAIT: edge with mem_rvalid=1 -> IDLE; next cycle done[owner]=1, err=0, rdata=mem_rdata (rdata=0 for writes); last_grant=owner.
REQ-026 Timeout: WAIT cycle counter; TIMEOUT_CYCLES-th WAIT cycle without mem_rvalid -> IDLE, done[owner]=1, err=1, rdata=0; last_grant=owner.
REQ-027 mem_rvalid coincident with the timeout cycle SHALL complete normally (err=0).
REQ-028 Turnaround: arbitration for the next request occurs on the edge after leaving WAIT; minimum transaction = 3 cycles req-to-done with mem_busy=0 and rvalid in first WAIT cycle.
REQ-029 req changes after gnt SHALL NOT affect the in-flight transaction.
REQ-030 done, gnt, err SHALL be low in all cycles other than those specified.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE from any state, abandoning in-flight transaction without done.
REQ-032 Reset values: gnt=0, done=0, err=0, rdata=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_we=0, last_grant=1 (req0 wins first tie), timeout counter=0, stat counters=0.

Configuration
REQ-033 Macro ARB_STATS_EN SHALL enable counters: stat_busy_cycles +1 per ISSUE cycle with mem_busy=1; stat_xfers +1 per done pulse (incl. err); both wrap at 2^64.
REQ-034 Without ARB_STATS_EN, stat_busy_cycles and stat_xfers SHALL be constant 0 and no counter flops exist; all other behaviour identical.

Verification
REQ-035 req=01, addr0=0x100, we0=0, mem_busy=0, mem_rvalid with mem_rdata=0xDEADBEEF in first WAIT cycle -> gnt=01 1 cycle after req, done=01 with rdata=0xDEADBEEF 3 cycles after req, err=0.
REQ-036 req=11 held from reset, three transactions -> grant order 0,1,0.
REQ-037 mem_busy=1 for 7 cycles during ISSUE -> mem_req and mem_addr stable 8 cycles, accepted on 8th; stat_busy_cycles=7 with ARB_STATS_EN, 0 without.
REQ-038 TIMEOUT_CYCLES=4, mem_rvalid never asserted -> done with err=1, rdata=0 after 4 WAIT cycles; stray mem_rvalid next cycle ignored.
REQ-039 rst=1 for 1 cycle in WAIT -> IDLE next cycle, no done pulse; late mem_rvalid ignored; next req=10 granted normally.
REQ-040 mem_rvalid on exact timeout cycle -> err=0, rdata=mem_rdata.
